// File: rtl/game_pkg.sv
// Shared encodings and defaults for the dino-runner game controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting right with feedback into bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int DEF_SCREEN_W = 800;
  localparam int DEF_GROUND_Y = 400;
  localparam int DEF_OBS_W    = 20;
  localparam int DEF_OBS_H    = 40;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/obs_slot.sv
// One scrolling obstacle slot: left edge, valid bit, and horizontal overlap with the dino box.
module obs_slot #(
  parameter int HOR_W = 11,
  parameter int OBS_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             move,
  input  logic             load,
  input  logic [HOR_W-1:0] load_x,
  input  logic [3:0]       speed,
  input  logic [HOR_W-1:0] dino_hor_from,
  input  logic [HOR_W-1:0] dino_hor_to,
  input  logic             ver_hit,
  output logic [HOR_W-1:0] x,
  output logic             active,
  output logic             hit
);

  logic [HOR_W:0] right_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      active <= 1'b0;
    end else if (clr) begin
      active <= 1'b0;
    end else if (load) begin
      x      <= load_x;
      active <= 1'b1;
    end else if (move && active) begin
      // An obstacle that would cross the left border is retired; x keeps its last value.
      if (x <= HOR_W'(speed)) active <= 1'b0;
      else                    x      <= x - HOR_W'(speed);
    end
  end

  assign right_edge = {1'b0, x} + (HOR_W+1)'(OBS_W - 1);
  assign hit = active && ver_hit && (x <= dino_hor_to) && (right_edge >= {1'b0, dino_hor_from});

endmodule

// File: rtl/game_controller.sv
// Dino-runner game state controller: FSM, obstacle slots, spawn scheduler, score and speed ramp.
// Optional GAME_CTRL_HISCORE_EN builds a best-score register; otherwise hiscore is tied to 0.
module game_controller
  import game_pkg::*;
#(
  parameter int N_OBS      = 3,
  parameter int HOR_W      = 11,
  parameter int VER_W      = 10,
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int OBS_W      = DEF_OBS_W,
  parameter int OBS_H      = DEF_OBS_H,
  parameter int GROUND_Y   = DEF_GROUND_Y,
  parameter int SPD_INIT   = 4,
  parameter int SPD_MAX    = 12,
  parameter int SCORE_STEP = 100,
  parameter int SCORE_W    = 16,
  parameter int MIN_GAP    = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   jump,
  input  logic [HOR_W-1:0]       dino_hor_from,
  input  logic [HOR_W-1:0]       dino_hor_to,
  input  logic [VER_W-1:0]       dino_ver_from,
  input  logic [VER_W-1:0]       dino_ver_to,
  output logic [N_OBS*HOR_W-1:0] obs_x,
  output logic [N_OBS-1:0]       obs_active,
  output logic [VER_W-1:0]       obs_ver_from,
  output logic [VER_W-1:0]       obs_ver_to,
  output logic [1:0]             state,
  output logic                   break_game,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     hiscore,
  output logic [3:0]             speed
);

  localparam logic [VER_W-1:0] OBS_VER_FROM = VER_W'(GROUND_Y - OBS_H + 1);
  localparam logic [VER_W-1:0] OBS_VER_TO   = VER_W'(GROUND_Y);
  localparam int               GAP_W        = HOR_W + 1;

  game_state_t        cur_state, next_state;
  logic [15:0]        lfsr;
  logic [GAP_W-1:0]   gap, gap_next;
  logic [SCORE_W-1:0] score_q, score_inc;
  logic [3:0]         speed_q;
  logic               break_q;
  logic               run_tick, restart, enter_over;
  logic               ver_hit, hit_any, spawn, speed_bump;
  logic [N_OBS-1:0]   slot_active, slot_hit, free_vec, lowest_free, load_vec;
  logic [HOR_W-1:0]   slot_x [N_OBS];

  always_ff @(posedge clk) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= next_state;
  end

  // Collision outranks a same-cycle frame_tick: the frame is simply not processed.
  always_comb begin
    next_state = cur_state;
    run_tick   = 1'b0;
    restart    = 1'b0;
    enter_over = 1'b0;
    case (cur_state)
      IDLE: if (jump) next_state = RUN;
      RUN: begin
        if (hit_any) begin
          next_state = OVER;
          enter_over = 1'b1;
        end else if (frame_tick) begin
          run_tick = 1'b1;
        end
      end
      OVER: begin
        if (jump) begin
          next_state = RUN;
          restart    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign ver_hit = (OBS_VER_FROM <= dino_ver_to) && (OBS_VER_TO >= dino_ver_from);
  assign hit_any = |slot_hit;

  // Lowest free slot as a one-hot vector; freeness is judged before this frame's moves.
  assign free_vec    = ~slot_active;
  assign lowest_free = free_vec & (~free_vec + N_OBS'(1));
  assign spawn       = run_tick && (gap == '0) && (|free_vec);
  assign load_vec    = spawn ? lowest_free : '0;

  always_comb begin
    score_inc  = (&score_q) ? score_q : score_q + SCORE_W'(1);
    speed_bump = (score_inc != '0) && ((score_inc % SCORE_W'(SCORE_STEP)) == '0) &&
                 (speed_q < 4'(SPD_MAX));
    gap_next   = gap;
    if (restart) begin
      gap_next = GAP_W'(MIN_GAP);
    end else if (run_tick) begin
      if (gap == '0) begin
        if (|free_vec) gap_next = GAP_W'(MIN_GAP) + GAP_W'(lfsr[7:0]);
      end else if (gap <= GAP_W'(speed_q)) begin
        gap_next = '0;
      end else begin
        gap_next = gap - GAP_W'(speed_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= LFSR_SEED;
      gap     <= GAP_W'(MIN_GAP);
      score_q <= '0;
      speed_q <= 4'(SPD_INIT);
      break_q <= 1'b0;
    end else begin
      lfsr    <= lfsr_step(lfsr);
      gap     <= gap_next;
      break_q <= (next_state == OVER);
      if (restart) begin
        score_q <= '0;
        speed_q <= 4'(SPD_INIT);
      end else if (run_tick) begin
        score_q <= score_inc;
        if (speed_bump) speed_q <= speed_q + 4'd1;
      end
    end
  end

  for (genvar i = 0; i < N_OBS; i++) begin : g_slot
    obs_slot #(
      .HOR_W (HOR_W),
      .OBS_W (OBS_W)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .clr           (restart),
      .move          (run_tick),
      .load          (load_vec[i]),
      .load_x        (HOR_W'(SCREEN_W)),
      .speed         (speed_q),
      .dino_hor_from (dino_hor_from),
      .dino_hor_to   (dino_hor_to),
      .ver_hit       (ver_hit),
      .x             (slot_x[i]),
      .active        (slot_active[i]),
      .hit           (slot_hit[i])
    );
    assign obs_x[i*HOR_W +: HOR_W] = slot_x[i];
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;
  always_ff @(posedge clk) begin
    if (rst)                                hiscore_q <= '0;
    else if (enter_over && score_q > hiscore_q) hiscore_q <= score_q;
  end
  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  assign obs_active   = slot_active;
  assign obs_ver_from = OBS_VER_FROM;
  assign obs_ver_to   = OBS_VER_TO;
  assign state        = cur_state;
  assign break_game   = break_q;
  assign score        = score_q;
  assign speed        = speed_q;

endmodule
